exe_stage_bru: RTL and testbench

EXE_STAGE_BRU -- requirements
Module: exe_stage_bru

---
 rtl/exe_stage_bru_pkg.sv | 28 ++
 rtl/exe_stage_bru_sat_cnt.sv | 24 ++
 rtl/exe_stage_bru.sv | 132 +++++++++++++
 tb/tb_exe_stage_bru.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_bru_pkg.sv
// Shared definitions for the EXE-stage branch resolution unit:
// bj bus bit positions, FSM encoding and the post-reset fetch address.
package exe_stage_bru_pkg;

  localparam int BJ_W    = 8;
  localparam int BJ_BEQ  = 0;
  localparam int BJ_BNE  = 1;
  localparam int BJ_BLT  = 2;
  localparam int BJ_BGE  = 3;
  localparam int BJ_BLTU = 4;
  localparam int BJ_BGEU = 5;
  localparam int BJ_JALR = 6;
  localparam int BJ_JAL  = 7;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } bru_state_e;

  // Exactly one type bit set; anything else resolves as a plain fall-through.
  function automatic logic is_onehot(input logic [BJ_W-1:0] v);
    return (v != {BJ_W{1'b0}}) &&
           ((v & (v - {{(BJ_W-1){1'b0}}, 1'b1})) == {BJ_W{1'b0}});
  endfunction

endpackage

// File: rtl/exe_stage_bru_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module bru_sat_cnt (
  input  logic        clk,
  input  logic        clear,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] count
);

  // Clear wins over load, load wins over increment; the max value is held.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/exe_stage_bru.sv
// Branch/jump resolution in EXE: computes the real next pc, checks it against
// the fetch prediction and holds a redirect request until fetch takes it.
module exe_stage_bru
  import exe_stage_bru_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BJ_W-1:0] bj_info,
  input  logic [BJ_W-1:0] bj_data,
  input  logic [63:0]     pc,
  input  logic [63:0]     imm,
  input  logic [63:0]     op1,
  input  logic            pred_taken,
  input  logic [63:0]     pred_pc,
  output logic [63:0]     link_data,
  output logic            link_valid,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [63:0]     redirect_pc,
  output logic            flush,
  output logic            misalign_exc,
  output logic [63:0]     misalign_addr,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mispred_cnt
);

  bru_state_e  state_r;
  logic        accept_s;
  logic        onehot_s;
  logic        jump_s;
  logic        taken_s;
  logic [63:0] seq_pc_s;
  logic [63:0] target_s;
  logic [63:0] next_pc_s;
  logic        misalign_s;
  logic        mispredict_s;
  logic        redir_req_s;
  logic        mispred_preload_s;

  assign in_ready = (state_r == IDLE);
  assign accept_s = in_valid && in_ready;

  // Resolve the instruction presented this cycle.
  always_comb begin
    onehot_s = is_onehot(bj_info);
    jump_s   = onehot_s && (bj_info[BJ_JAL] || bj_info[BJ_JALR]);
    taken_s  = onehot_s && ((|(bj_info & bj_data)) || jump_s);
    seq_pc_s = pc + 64'd4;
    if (onehot_s && bj_info[BJ_JALR]) begin
      target_s = (op1 + imm) & ~64'h1;
    end else begin
      target_s = pc + imm;
    end
    next_pc_s    = taken_s ? target_s : seq_pc_s;
    misalign_s   = taken_s && target_s[1];
    mispredict_s = (taken_s != pred_taken) || (taken_s && (target_s != pred_pc));
    redir_req_s  = accept_s && !misalign_s && mispredict_s;
  end

  // Redirect FSM plus the one-cycle link/exception/flush pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
      flush          <= 1'b0;
      link_valid     <= 1'b0;
      link_data      <= 64'd0;
      misalign_exc   <= 1'b0;
      misalign_addr  <= 64'd0;
    end else begin
      flush        <= 1'b0;
      link_valid   <= 1'b0;
      misalign_exc <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (jump_s) begin
              link_valid <= 1'b1;
              link_data  <= seq_pc_s;
            end
            if (misalign_s) begin
              misalign_exc  <= 1'b1;
              misalign_addr <= target_s;
            end else if (mispredict_s) begin
              state_r        <= REDIR;
              redirect_valid <= 1'b1;
              redirect_pc    <= next_pc_s;
            end
          end
        end
        REDIR: begin
          if (redirect_ready) begin
            state_r        <= IDLE;
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
          end
        end
        default: begin
          state_r        <= IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  // Preload hook for the mispredict counter, tied off in normal operation.
  assign mispred_preload_s = 1'b0;

  bru_sat_cnt u_br_cnt (
    .clk      (clk),
    .clear    (rst),
    .inc      (accept_s),
    .load     (1'b0),
    .load_val (32'd0),
    .count    (br_cnt)
  );

  bru_sat_cnt u_mispred_cnt (
    .clk      (clk),
    .clear    (rst),
    .inc      (redir_req_s),
    .load     (mispred_preload_s),
    .load_val (32'hFFFF_FFFF),
    .count    (mispred_cnt)
  );

endmodule

// File: tb/tb_exe_stage_bru.sv
// Directed bench for exe_stage_bru: hand-computed expectations checked with
// immediate assertions one cycle after each driven edge.
module tb_exe_stage_bru;
  import exe_stage_bru_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BJ_W-1:0] bj_info;
  logic [BJ_W-1:0] bj_data;
  logic [63:0]     pc;
  logic [63:0]     imm;
  logic [63:0]     op1;
  logic            pred_taken;
  logic [63:0]     pred_pc;
  logic [63:0]     link_data;
  logic            link_valid;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [63:0]     redirect_pc;
  logic            flush;
  logic            misalign_exc;
  logic [63:0]     misalign_addr;
  logic [31:0]     br_cnt;
  logic [31:0]     mispred_cnt;

  int tests = 0;
  int fails = 0;
  int flush_seen;

  exe_stage_bru dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .bj_info        (bj_info),
    .bj_data        (bj_data),
    .pc             (pc),
    .imm            (imm),
    .op1            (op1),
    .pred_taken     (pred_taken),
    .pred_pc        (pred_pc),
    .link_data      (link_data),
    .link_valid     (link_valid),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .misalign_exc   (misalign_exc),
    .misalign_addr  (misalign_addr),
    .br_cnt         (br_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] info, input logic [7:0] data, input logic [63:0] p,
                       input logic [63:0] im, input logic [63:0] o1, input logic pt,
                       input logic [63:0] pp);
    in_valid   = 1'b1;
    bj_info    = info;
    bj_data    = data;
    pc         = p;
    imm        = im;
    op1        = o1;
    pred_taken = pt;
    pred_pc    = pp;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; redirect_ready = 1'b0;
    bj_info = 8'h00; bj_data = 8'h00; pc = 64'd0; imm = 64'd0; op1 = 64'd0;
    pred_taken = 1'b0; pred_pc = 64'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'h0000_0000_8000_0000);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_link_data", link_data, 64'd0);
    chk("rst_counters", {br_cnt, mispred_cnt}, 64'd0);
    chk("rst_pulses", {61'd0, flush, link_valid, misalign_exc}, 64'd0);

    // BEQ taken, predicted not-taken
    drive(8'h01, 8'h01, 64'h8000_0000, 64'h10, 64'd0, 1'b0, 64'h8000_0004);
    tick();
    in_valid = 1'b0;
    chk("beq_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    chk("beq_redirect_pc", redirect_pc, 64'h8000_0010);
    chk("beq_in_ready", {63'd0, in_ready}, 64'd0);
    chk("beq_cnts", {br_cnt, mispred_cnt}, {32'd1, 32'd1});
    chk("beq_no_early_flush", {63'd0, flush}, 64'd0);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("beq_flush", {63'd0, flush}, 64'd1);
    chk("beq_released", {62'd0, redirect_valid, in_ready}, 64'd1);
    tick();
    chk("beq_flush_pulse", {63'd0, flush}, 64'd0);
    // ready with no pending redirect is ignored
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("idle_ready_ignored", {62'd0, flush, redirect_valid}, 64'd0);

    // BNE not taken, predicted not-taken: back-to-back pair
    drive(8'h02, 8'h00, 64'h8000_0020, 64'h40, 64'd0, 1'b0, 64'h8000_0024);
    tick();
    chk("bne1_no_redirect", {63'd0, redirect_valid}, 64'd0);
    drive(8'h02, 8'h00, 64'h8000_0024, 64'h40, 64'd0, 1'b0, 64'h8000_0028);
    tick();
    in_valid = 1'b0;
    chk("bne2_no_redirect", {63'd0, redirect_valid}, 64'd0);
    chk("bne_cnts", {br_cnt, mispred_cnt}, {32'd3, 32'd1});

    // JALR to a 2-byte-aligned target
    drive(8'h40, 8'h00, 64'h8000_0100, 64'd0, 64'h8000_1003, 1'b1, 64'h8000_1002);
    tick();
    in_valid = 1'b0;
    chk("jalr_misalign_exc", {63'd0, misalign_exc}, 64'd1);
    chk("jalr_misalign_addr", misalign_addr, 64'h8000_1002);
    chk("jalr_link", {63'd0, link_valid}, 64'd1);
    chk("jalr_link_data", link_data, 64'h8000_0104);
    chk("jalr_no_redirect", {63'd0, redirect_valid}, 64'd0);
    chk("jalr_cnts", {br_cnt, mispred_cnt}, {32'd4, 32'd1});
    tick();
    chk("jalr_pulses_end", {62'd0, misalign_exc, link_valid}, 64'd0);

    // BLT taken backwards, fetch stalls the redirect for 5 cycles
    drive(8'h04, 8'h04, 64'h8000_0200, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0, 64'h8000_0204);
    tick();
    drive(8'h01, 8'h01, 64'h8000_0500, 64'h10, 64'd0, 1'b0, 64'h8000_0504);
    flush_seen = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {63'd0, redirect_valid}, 64'd1);
      chk("stall_pc", redirect_pc, 64'h8000_01F8);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      flush_seen += int'(flush);
      tick();
    end
    in_valid = 1'b0;
    chk("stall_cnts", {br_cnt, mispred_cnt}, {32'd5, 32'd2});
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    flush_seen += int'(flush);
    tick();
    flush_seen += int'(flush);
    tick();
    flush_seen += int'(flush);
    chk("stall_flush_once", 64'(flush_seen), 64'd1);

    // JAL correctly predicted
    drive(8'h80, 8'h00, 64'h8000_0300, 64'h20, 64'd0, 1'b1, 64'h8000_0320);
    tick();
    in_valid = 1'b0;
    chk("jal_link", {63'd0, link_valid}, 64'd1);
    chk("jal_link_data", link_data, 64'h8000_0304);
    chk("jal_no_redirect", {63'd0, redirect_valid}, 64'd0);
    chk("jal_cnts", {br_cnt, mispred_cnt}, {32'd6, 32'd2});

    // BGEU taken with right direction but wrong target
    drive(8'h20, 8'h20, 64'h8000_0400, 64'h100, 64'd0, 1'b1, 64'h8000_0480);
    tick();
    in_valid = 1'b0;
    chk("bgeu_target_redirect", redirect_pc, 64'h8000_0500);
    chk("bgeu_cnts", {br_cnt, mispred_cnt}, {32'd7, 32'd3});
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;

    // Non-one-hot type is a fall-through; predicted taken -> redirect to pc+4
    drive(8'h03, 8'h03, 64'h8000_0600, 64'h40, 64'd0, 1'b1, 64'h8000_0640);
    tick();
    in_valid = 1'b0;
    chk("nonhot_redirect_pc", redirect_pc, 64'h8000_0604);
    chk("nonhot_cnts", {br_cnt, mispred_cnt}, {32'd8, 32'd4});
    chk("nonhot_no_link", {63'd0, link_valid}, 64'd0);

    // Reset while a redirect is pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_redir_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rst_redir_pc", redirect_pc, 64'h8000_0000);
    chk("rst_redir_cnts", {br_cnt, mispred_cnt}, 64'd0);
    chk("rst_redir_no_flush", {63'd0, flush}, 64'd0);
    tick();
    chk("rst_redir_no_flush_after", {62'd0, flush, in_ready}, 64'd1);

    // Mispredict counter saturation
    force dut.mispred_preload_s = 1'b1;
    tick();
    release dut.mispred_preload_s;
    chk("sat_preload", {32'd0, mispred_cnt}, 64'h0000_0000_FFFF_FFFF);
    drive(8'h01, 8'h01, 64'h8000_0000, 64'h10, 64'd0, 1'b0, 64'h8000_0004);
    tick();
    in_valid = 1'b0;
    chk("sat_redirect", {63'd0, redirect_valid}, 64'd1);
    chk("sat_hold", {32'd0, mispred_cnt}, 64'h0000_0000_FFFF_FFFF);
    chk("sat_br_cnt", {32'd0, br_cnt}, 64'd1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("sat_flush", {63'd0, flush}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
